// File: rtl/shift_op_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module  : shift_seq_pkg
// Brief   : Shared state encoding and constants for the shift-op sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int   STEP_MAX  = 3;
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

`default_nettype wire

// File: rtl/shift_op_sequencer_if.sv
//------------------------------------------------------------------------------
// Module  : shift_op_sequencer_if
// Brief   : Request/response valid-ready bundle between a client and the sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface shift_op_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic [AMT_W-1:0] req_amt;
  logic             req_dir;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_ovr;

  modport master (
    output req_valid, req_data, req_amt, req_dir, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_ovr
  );

  modport slave (
    input  req_valid, req_data, req_amt, req_dir, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_ovr
  );
endinterface

`default_nettype wire

// File: rtl/shift_op_sequencer.sv
//------------------------------------------------------------------------------
// Module  : shift_op_sequencer
// Brief   : Splits a 0..15 shift into passes of at most 3 on an external registered
//           shifter, accumulating a sticky overflow flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_op_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  shift_op_sequencer_if.slave   bus,
  output logic                  busy,
  output logic [WIDTH-1:0]      sh_number,
  output logic [1:0]            sh_amt,
  output logic                  sh_md,
  input  wire logic [WIDTH-1:0] sh_result,
  input  wire logic             sh_ovr
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             ovr_q, ovr_d;
  logic [1:0]       step;

  // rem_q is unchanged between ISSUE and CAPT, so step is the same in both.
  assign step = (rem_q > AMT_W'(STEP_MAX)) ? 2'(STEP_MAX) : rem_q[1:0];

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_data  = work_q;
  assign bus.rsp_ovr   = ovr_q;
  assign busy          = (state_q != IDLE);
  assign sh_number     = work_q;
  assign sh_md         = dir_q;
  assign sh_amt        = (state_q == ISSUE) ? step : 2'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      dir_q   <= DIR_RIGHT;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          work_d  = bus.req_data;
          rem_d   = bus.req_amt;
          dir_d   = bus.req_dir;
          ovr_d   = 1'b0;
          state_d = (bus.req_amt == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: state_d = CAPT;
      CAPT: begin
        work_d  = sh_result;
        ovr_d   = ovr_q | sh_ovr;
        rem_d   = rem_q - AMT_W'(step);
        state_d = (rem_q == AMT_W'(step)) ? DONE : ISSUE;
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_op_sequencer.sv
//------------------------------------------------------------------------------
// Module  : tb_shift_op_sequencer
// Brief   : Scoreboard bench for shift_op_sequencer with a registered shifter model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [7:0] sh_number;
  logic [1:0] sh_amt;
  logic       sh_md;
  logic [7:0] sh_result;
  logic       sh_ovr;
  logic       hold_rsp;

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;

  typedef struct {
    logic [7:0] data;
    logic       ovr;
    int         amt;
    int         acc;
  } exp_t;

  exp_t exp_q[$];

  shift_op_sequencer_if #(.WIDTH(8), .AMT_W(4)) bus ();

  shift_op_sequencer #(.WIDTH(8), .AMT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .sh_number (sh_number),
    .sh_amt    (sh_amt),
    .sh_md     (sh_md),
    .sh_result (sh_result),
    .sh_ovr    (sh_ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered PIPO shifter: one pass of 0..3 positions, flags any 1 shifted out.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_result <= 8'd0;
      sh_ovr    <= 1'b0;
    end else if (sh_md) begin
      sh_result <= 8'((16'(sh_number) << sh_amt));
      sh_ovr    <= |((16'(sh_number) << sh_amt) >> 8);
    end else begin
      sh_result <= sh_number >> sh_amt;
      sh_ovr    <= |(sh_number & 8'((1 << sh_amt) - 1));
    end
  end

  always @(posedge clk) begin
    #1;
    bus.rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-request reference: one shift by the full amount over a wide word.
  function automatic exp_t ref_model(input logic [7:0] d, input int amt, input logic dir);
    logic [23:0] e;
    exp_t r;
    if (dir) begin
      e = {16'd0, d} << amt;
      r.data = e[7:0];
      r.ovr  = |e[23:8];
    end else begin
      e = {d, 16'd0} >> amt;
      r.data = e[23:16];
      r.ovr  = |e[15:0];
    end
    r.amt = amt;
    r.acc = 0;
    return r;
  endfunction

  // Expected pass list as {count, 2-bit amounts packed oldest-first}.
  function automatic logic [31:0] pass_seq(input int amt);
    int r = amt;
    logic [15:0] cnt = 0;
    logic [15:0] pk = 0;
    while (r > 0) begin
      pk = (pk << 2) | 16'(r > 3 ? 3 : r);
      r  = r - (r > 3 ? 3 : r);
      cnt++;
    end
    return {cnt, pk};
  endfunction

  task automatic send(input logic [7:0] d, input int amt, input logic dir);
    exp_t e;
    int   n = 0;
    bus.req_valid = 1'b1;
    bus.req_data  = d;
    bus.req_amt   = 4'(amt);
    bus.req_dir   = dir;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready && n < 300);
    if (!bus.req_ready) begin
      vectors++;
      fails++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 300 cycles");
    end else begin
      e     = ref_model(d, amt, dir);
      e.acc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    #1;
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  logic        rv_prev = 1'b0;
  int          rise    = 0;
  logic [7:0]  held_data;
  logic        held_ovr;
  logic [15:0] obs_cnt = 0;
  logic [15:0] obs_pk  = 0;
  exp_t        m;

  always @(negedge clk) begin
    if (rst) begin
      rv_prev = 1'b0;
      obs_cnt = 0;
      obs_pk  = 0;
    end else begin
      if (sh_amt != 2'd0) begin
        obs_pk  = (obs_pk << 2) | 16'(sh_amt);
        obs_cnt = obs_cnt + 1;
      end
      if (bus.rsp_valid && !rv_prev) rise = cyc;
      if (bus.rsp_valid) begin
        chk("req_ready_in_done", 32'(bus.req_ready), 32'd0);
        if (rv_prev) begin
          chk("rsp_data_stable", 32'(bus.rsp_data), 32'(held_data));
          chk("rsp_ovr_stable", 32'(bus.rsp_ovr), 32'(held_ovr));
        end
        held_data = bus.rsp_data;
        held_ovr  = bus.rsp_ovr;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          fails++;
          $display("FAIL unexpected_rsp: got data %0h expected no response", bus.rsp_data);
        end else begin
          m = exp_q.pop_front();
          chk("rsp_data", 32'(bus.rsp_data), 32'(m.data));
          chk("rsp_ovr", 32'(bus.rsp_ovr), 32'(m.ovr));
          chk("latency", 32'(rise - (m.acc + 1)),
              32'(m.amt == 0 ? 0 : 2 * ((m.amt + 2) / 3)));
          chk("sh_amt_seq", {obs_cnt, obs_pk}, pass_seq(m.amt));
        end
        obs_cnt = 0;
        obs_pk  = 0;
      end
      rv_prev = bus.rsp_valid;
    end
  end

  initial begin
    int seen;
    int n;
    rst           = 1'b1;
    hold_rsp      = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_data  = 8'd0;
    bus.req_amt   = 4'd0;
    bus.req_dir   = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_rsp_ovr", 32'(bus.rsp_ovr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sh_number", 32'(sh_number), 32'd0);
    chk("rst_sh_amt", 32'(sh_amt), 32'd0);
    chk("rst_sh_md", 32'(sh_md), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(8'b0110_1001, 2, 1'b1);
    send(8'b0110_1001, 5, 1'b1);
    send(8'b1000_0000, 7, 1'b0);
    send(8'hA5, 0, 1'b1);
    drain();

    hold_rsp = 1'b1;
    fork
      begin
        send(8'hC3, 2, 1'b1);
        send(8'h5A, 4, 1'b0);
      end
      begin
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("bp_rsp_seen", 32'(bus.rsp_valid), 32'd1);
        repeat (3) @(posedge clk);
        hold_rsp = 1'b0;
      end
    join
    drain();

    repeat (40) send(8'($urandom), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    drain();

    send(8'hFF, 15, 1'b1);
    seen = 0;
    n    = 0;
    while (seen < 2 && n < 100) begin
      @(negedge clk);
      if (sh_amt != 2'd0) seen++;
      n++;
    end
    chk("mid_rst_second_issue", 32'(seen), 32'd2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("mid_rst_sh_amt", 32'(sh_amt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h81, 1, 1'b1);
    drain();
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

`default_nettype wire
